proc_settle_sched: RTL and testbench

Hardware evaluation scheduler for a small set of combinational "processes" (continuous assignments and always_comb-style blocks) that share one evaluation engine. It accepts an initial activation set and issues one process at a time to the engine. When a process reports that its outputs changed, it re-activates the dependents given by a sensitivity matrix. It iterates until nothing is pending (settled) or an evaluation budget runs out (loop error), so the same process can be re-run within one settle, as an always_comb fed back through a continuous assignment must be.

---
 rtl/proc_settle_sched.sv | 156 +++++++++++++++
 tb/tb_proc_settle_sched.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_settle_sched.sv
// proc_settle_sched: schedules combinational processes onto one shared
// evaluation engine, re-activating dependents of any process whose outputs
// changed, until the pending set drains (settled) or the evaluation budget
// runs out (loop error).
module proc_settle_sched #(
    parameter int N         = 4,
    parameter int MAX_EVALS = 16,
    parameter int IW        = $clog2(N),
    parameter int CW        = $clog2(MAX_EVALS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*N-1:0]   sens_i,
    input  logic             start_i,
    input  logic [N-1:0]     trig_i,
    output logic             run_valid_o,
    output logic [IW-1:0]    run_id_o,
    input  logic             done_i,
    input  logic             changed_i,
    output logic             busy_o,
    output logic             settled_o,
    output logic             loop_err_o,
    output logic [CW-1:0]    eval_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PICK = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    pending_q, pending_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   cur_id_q, cur_id_d;
    logic            run_valid_q, run_valid_d;
    logic            settled_q, settled_d;
    logic            loop_err_q, loop_err_d;

    // Row i of the sensitivity matrix: the processes that depend on process i.
    logic [N-1:0]    sens_row [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_sens_row
        assign sens_row[gi] = sens_i[gi*N +: N];
    end

    // Round-robin pick: the first pending process at or after ptr, wrapping.
    logic [IW-1:0]   pick_id;
    logic [IW-1:0]   pick_next_ptr;
    int              scan_idx;

    // Scan from the far end back to ptr so the closest pending bit wins.
    always_comb begin
        pick_id  = '0;
        scan_idx = 0;
        for (int k = N - 1; k >= 0; k--) begin
            scan_idx = (int'(ptr_q) + k) % N;
            if (pending_q[scan_idx]) begin
                pick_id = IW'(scan_idx);
            end
        end
        pick_next_ptr = (pick_id == IW'(N - 1)) ? '0 : pick_id + IW'(1);
    end

    // Next-state and register-update logic for the IDLE/PICK/RUN scheduler.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        cur_id_d    = cur_id_q;
        run_valid_d = run_valid_q;
        settled_d   = 1'b0;
        loop_err_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    cnt_d = '0;
                    if (trig_i != '0) begin
                        pending_d = trig_i;
                        state_d   = ST_PICK;
                    end else begin
                        // Nothing to evaluate: the settle is trivially complete.
                        settled_d = 1'b1;
                    end
                end
            end

            ST_PICK: begin
                if (pending_q == '0) begin
                    settled_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (cnt_q == CW'(MAX_EVALS)) begin
                    loop_err_d = 1'b1;
                    pending_d  = '0;
                    state_d    = ST_IDLE;
                end else begin
                    pending_d[pick_id] = 1'b0;
                    cur_id_d           = pick_id;
                    run_valid_d        = 1'b1;
                    cnt_d              = cnt_q + CW'(1);
                    ptr_d              = pick_next_ptr;
                    state_d            = ST_RUN;
                end
            end

            ST_RUN: begin
                if (done_i) begin
                    run_valid_d = 1'b0;
                    if (changed_i) begin
                        // Includes the self-bit, so a process can re-arm itself.
                        pending_d = pending_q | sens_row[cur_id_q];
                    end
                    state_d = ST_PICK;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; a reset mid-run drops the grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            cur_id_q    <= '0;
            run_valid_q <= 1'b0;
            settled_q   <= 1'b0;
            loop_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            cur_id_q    <= cur_id_d;
            run_valid_q <= run_valid_d;
            settled_q   <= settled_d;
            loop_err_q  <= loop_err_d;
        end
    end

    assign run_valid_o = run_valid_q;
    assign run_id_o    = cur_id_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign settled_o   = settled_q;
    assign loop_err_o  = loop_err_q;
    assign eval_cnt_o  = cnt_q;

endmodule

// File: tb/tb_proc_settle_sched.sv
// Bench for proc_settle_sched: an evaluation-order model predicts grants and
// settle outcomes into a queue; a monitor checks DUT events against it.
module tb_proc_settle_sched;

    localparam int N         = 4;
    localparam int MAX_EVALS = 16;
    localparam int IW        = 2;
    localparam int CW        = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [N*N-1:0]   sens_i;
    logic             start_i;
    logic [N-1:0]     trig_i;
    logic             run_valid_o;
    logic [IW-1:0]    run_id_o;
    logic             done_i;
    logic             changed_i;
    logic             busy_o;
    logic             settled_o;
    logic             loop_err_o;
    logic [CW-1:0]    eval_cnt_o;

    proc_settle_sched #(.N(N), .MAX_EVALS(MAX_EVALS)) dut (
        .clk         (clk),
        .rst         (rst),
        .sens_i      (sens_i),
        .start_i     (start_i),
        .trig_i      (trig_i),
        .run_valid_o (run_valid_o),
        .run_id_o    (run_id_o),
        .done_i      (done_i),
        .changed_i   (changed_i),
        .busy_o      (busy_o),
        .settled_o   (settled_o),
        .loop_err_o  (loop_err_o),
        .eval_cnt_o  (eval_cnt_o)
    );

    always #5 clk = ~clk;

    // Expected events: kind 0 = grant (val = id), 1 = settled, 2 = loop error (val = count).
    typedef struct {
        int kind;
        int val;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   model_ptr = 0;
    bit   chg_arr [MAX_EVALS];

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic pop_check(input int kind, input int val, input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got unexpected event kind %0d val %0d, want none", name, kind, val);
        end else begin
            e = exp_q.pop_front();
            check({name, "_kind"}, kind, e.kind);
            check(name, val, e.val);
            $display("event kind=%0d val=%0d expected kind=%0d val=%0d", kind, val, e.kind, e.val);
        end
    endtask

    // Reference: walk the pending set as a plain array, in evaluation order.
    function automatic void model_settle(input logic [N*N-1:0] sens, input logic [N-1:0] trig);
        bit pend [N];
        int cnt = 0;
        int id;
        bit any;
        bit fin = 0;
        exp_t e;
        for (int i = 0; i < N; i++) pend[i] = trig[i];
        while (!fin) begin
            any = 0;
            for (int i = 0; i < N; i++) any |= pend[i];
            if (!any) begin
                e.kind = 1; e.val = cnt; exp_q.push_back(e); fin = 1;
            end else if (cnt == MAX_EVALS) begin
                e.kind = 2; e.val = cnt; exp_q.push_back(e); fin = 1;
            end else begin
                id = -1;
                for (int k = 0; k < N; k++) begin
                    if (id < 0 && pend[(model_ptr + k) % N]) id = (model_ptr + k) % N;
                end
                pend[id] = 0;
                e.kind = 0; e.val = id; exp_q.push_back(e);
                model_ptr = (id + 1) % N;
                if (chg_arr[cnt]) begin
                    for (int j = 0; j < N; j++) if (sens[id*N + j]) pend[j] = 1;
                end
                cnt++;
            end
        end
    endfunction

    // Monitor: compares every grant and every settle outcome against the queue.
    bit prev_valid = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                prev_valid = 0;
            end else begin
                if (run_valid_o && !prev_valid) pop_check(0, int'(run_id_o), "grant_id");
                if (settled_o) begin
                    pop_check(1, int'(eval_cnt_o), "settle_cnt");
                    check("busy_at_settle", int'(busy_o), 0);
                end
                if (loop_err_o) begin
                    pop_check(2, int'(eval_cnt_o), "loop_err_cnt");
                    check("busy_at_loop_err", int'(busy_o), 0);
                end
                prev_valid = run_valid_o;
            end
        end
    end

    // One settle: predict, start, and act as the engine until it finishes.
    task automatic run_settle(input logic [N*N-1:0] sens, input logic [N-1:0] trig, input bit rand_lat);
        int idx = 0;
        int wait_cnt = 0;
        int cyc = 0;
        bit fin = 0;
        sens_i = sens;
        model_settle(sens, trig);
        @(negedge clk);
        start_i = 1'b1;
        trig_i  = trig;
        @(negedge clk);
        start_i = 1'b0;
        while (!fin) begin
            if (settled_o || loop_err_o) begin
                fin = 1;
            end else if (cyc > 2000) begin
                check("settle_timeout", 1, 0);
                fin = 1;
            end else begin
                if (done_i) begin
                    done_i   = 1'b0;
                    idx++;
                    wait_cnt = rand_lat ? int'($urandom_range(0, 2)) : 0;
                end else if (run_valid_o) begin
                    if (wait_cnt == 0) begin
                        done_i    = 1'b1;
                        changed_i = (idx < MAX_EVALS) ? chg_arr[idx] : 1'b0;
                    end else begin
                        wait_cnt--;
                    end
                end
                cyc++;
                @(negedge clk);
            end
        end
        done_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        model_ptr = 0;
    endtask

    task automatic set_chg(input bit all_one, input bit [MAX_EVALS-1:0] pat);
        for (int i = 0; i < MAX_EVALS; i++) chg_arr[i] = all_one ? 1'b1 : pat[i];
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; trig_i = '0; sens_i = '0; done_i = 1'b0; changed_i = 1'b0;

        // Reset with a start request asserted throughout.
        @(negedge clk);
        start_i = 1'b1; trig_i = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        check("rst_run_valid", int'(run_valid_o), 0);
        check("rst_run_id", int'(run_id_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_settled", int'(settled_o), 0);
        check("rst_loop_err", int'(loop_err_o), 0);
        check("rst_eval_cnt", int'(eval_cnt_o), 0);
        rst = 1'b0; start_i = 1'b0; trig_i = '0;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_run_valid", int'(run_valid_o), 0);
        check("post_rst_busy", int'(busy_o), 0);

        // Single pass, no dependents: grants 0 then 2.
        set_chg(1, '0);
        run_settle(16'h0000, 4'b0101, 0);

        // Feedback: P0 and P1 depend on each other; last evaluation reports no change.
        do_reset();
        set_chg(0, 16'b0111);
        run_settle(16'h0012, 4'b0011, 1);

        // Combinational loop exhausts the budget, then an empty start and a normal start.
        set_chg(1, '0);
        run_settle(16'h0012, 4'b0001, 0);
        run_settle(16'h0000, 4'b0000, 0);
        run_settle(16'h0000, 4'b1000, 1);

        // Fairness: self-sensitive P2 monopolises once P0 has run; later starts reach P0.
        do_reset();
        run_settle(16'h0400, 4'b0101, 0);
        run_settle(16'h0000, 4'b0101, 1);

        // Mid-run: start is ignored in RUN, and reset drops the grant silently.
        set_chg(1, '0);
        sens_i = 16'h0000;
        model_settle(16'h0000, 4'b0110);
        @(negedge clk);
        start_i = 1'b1; trig_i = 4'b0110;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 10 && !run_valid_o; i++) @(negedge clk);
        check("midrun_valid_seen", int'(run_valid_o), 1);
        start_i = 1'b1; trig_i = 4'b1111;
        @(negedge clk);
        start_i = 1'b0;
        check("midrun_start_ignored_valid", int'(run_valid_o), 1);
        check("midrun_start_ignored_cnt", int'(eval_cnt_o), 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrun_rst_valid", int'(run_valid_o), 0);
        check("midrun_rst_settled", int'(settled_o), 0);
        check("midrun_rst_loop_err", int'(loop_err_o), 0);
        check("midrun_rst_busy", int'(busy_o), 0);
        rst = 1'b0;
        exp_q.delete();
        model_ptr = 0;
        @(negedge clk);
        check("midrun_post_settled", int'(settled_o), 0);
        check("midrun_post_loop_err", int'(loop_err_o), 0);

        // Randomised settles with random dependencies, changes and latencies.
        for (int t = 0; t < 40; t++) begin
            bit [MAX_EVALS-1:0] pat;
            pat = MAX_EVALS'($urandom) & MAX_EVALS'($urandom | $urandom);
            set_chg(0, pat);
            run_settle(N*N'($urandom), N'($urandom), 1);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
